// File: rtl/biu_pkg.sv
// Shared types and widths for the 8088-style bus interface unit.
// Includes the one-hot bus state encoding and the latched request record.
package biu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 20;

    typedef enum logic [6:0] {
        TI = 7'b0000001,
        T1 = 7'b0000010,
        T2 = 7'b0000100,
        T3 = 7'b0001000,
        TW = 7'b0010000,
        T4 = 7'b0100000,
        TH = 7'b1000000
    } bus_state_t;

    typedef struct packed {
        logic              we;
        logic              iom;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // States in which the data strobes and DEN are active.
    function automatic logic is_strobe(input bus_state_t s);
        return (s == T2) || (s == T3) || (s == TW);
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Execution-side req/ack handshake plus the minimum-mode bus pins.
// master = the cycle controller, slave = the requester/memory environment around it.
interface bus_cycle_ctrl_if;
    import biu_pkg::*;

    logic              req;
    logic              req_we;
    logic              req_iom;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              READY;
    logic [DATA_W-1:0] Data_in;
    logic [DATA_W-1:0] Data_out;
    logic              Data_oe;
    logic [ADDR_W-1:0] Address;
    logic              ALE;
    logic              IOM;
    logic              RD;
    logic              WR;
    logic              DTR;
    logic              DEN;
    logic              HOLD;
    logic              HLDA;
    logic              bus_oe;

    modport master (
        input  req, req_we, req_iom, req_addr, req_wdata, READY, Data_in, HOLD,
        output ack, err, rdata, busy, Data_out, Data_oe, Address, ALE, IOM,
               RD, WR, DTR, DEN, HLDA, bus_oe
    );

    modport slave (
        output req, req_we, req_iom, req_addr, req_wdata, READY, Data_in, HOLD,
        input  ack, err, rdata, busy, Data_out, Data_oe, Address, ALE, IOM,
               RD, WR, DTR, DEN, HLDA, bus_oe
    );

endinterface

// File: rtl/wait_timer.sv
// Counts TW cycles; expired flags the TW cycle that brings the count to MAX_WAIT.
// Combinational expired, no backpressure; counter saturates at MAX_WAIT.
module wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic cnt_en,
    output logic expired
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_en && (cnt_q < MAX_CNT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = cnt_en && (cnt_q >= (MAX_CNT - 8'd1));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8088 minimum-mode bus cycle generator: T1-T4 with READY wait states, timeout, HOLD/HLDA.
// Zero-wait cycle acks 4 cycles after accept; req is held off (no ack) until the cycle ends.
module bus_cycle_ctrl
    import biu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic             CLK,
    input  logic             RESET,
    bus_cycle_ctrl_if.master bus
);

    bus_state_t state_q, state_d;
    bus_req_t   req_q, req_d;

    logic              accept;
    logic              timeout;
    logic              expired;
    logic              strobe;

    logic              ale_q, ale_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              den_n_q, den_n_d;
    logic              data_oe_q, data_oe_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              hlda_q, hlda_d;

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (state_q == T2),
        .cnt_en  (state_q == TW),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            TI: begin
                if (bus.HOLD) begin
                    state_d = TH;
                end else if (bus.req) begin
                    state_d = T1;
                    accept  = 1'b1;
                end
            end
            T1: state_d = T2;
            T2: state_d = T3;
            // The counter was cleared in T2, so T3 can always fall into TW.
            T3: state_d = bus.READY ? T4 : TW;
            TW: begin
                if (bus.READY) begin
                    state_d = T4;
                end else if (expired) begin
                    state_d = T4;
                    timeout = 1'b1;
                end
            end
            T4: state_d = TI;
            TH: if (!bus.HOLD) state_d = TI;
            default: state_d = TI;
        endcase
    end

    // Outputs decode the next state so they change on the edge entering it.
    always_comb begin
        req_d      = req_q;
        strobe     = is_strobe(state_d);
        if (accept) begin
            req_d = '{we: bus.req_we, iom: bus.req_iom, addr: bus.req_addr, wdata: bus.req_wdata};
        end
        ale_d      = (state_d == T1);
        rd_n_d     = !(strobe && !req_q.we);
        wr_n_d     = !(strobe && req_q.we);
        den_n_d    = !strobe;
        data_oe_d  = strobe && req_q.we;
        data_out_d = data_oe_d ? req_q.wdata : data_out_q;
        ack_d      = (state_d == T4);
        err_d      = timeout;
        busy_d     = state_d inside {T1, T2, T3, TW, T4};
        hlda_d     = (state_d == TH);
        rdata_d    = rdata_q;
        if (timeout) begin
            rdata_d = 8'hFF;
        end else if ((state_q inside {T3, TW}) && bus.READY && !req_q.we) begin
            rdata_d = bus.Data_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= TI;
            req_q      <= '{we: 1'b1, iom: 1'b0, addr: '0, wdata: '0};
            ale_q      <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            den_n_q    <= 1'b1;
            data_oe_q  <= 1'b0;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            hlda_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            ale_q      <= ale_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            den_n_q    <= den_n_d;
            data_oe_q  <= data_oe_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            hlda_q     <= hlda_d;
        end
    end

    // Address, IOM and DTR come straight from the latched request; reset leaves DTR in transmit.
    assign bus.Address  = req_q.addr;
    assign bus.IOM      = req_q.iom;
    assign bus.DTR      = req_q.we;
    assign bus.ALE      = ale_q;
    assign bus.RD       = rd_n_q;
    assign bus.WR       = wr_n_q;
    assign bus.DEN      = den_n_q;
    assign bus.Data_oe  = data_oe_q;
    assign bus.Data_out = data_out_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.HLDA     = hlda_q;
    assign bus.bus_oe   = !hlda_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed plus randomized bench for bus_cycle_ctrl; expectations come from cycle arithmetic
// (ack at accept+4+W, strobes for 2+W cycles) and a running model of rdata.
module tb_bus_cycle_ctrl;

    localparam int MAXW = 15;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    bus_cycle_ctrl_if bif ();

    bus_cycle_ctrl #(.MAX_WAIT(MAXW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bif)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_rdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One bus cycle. k = cycles READY is held low starting at T3.
    task automatic xfer(input logic we, input logic iom, input logic [19:0] addr,
                        input logic [7:0] wd, input logic [7:0] din, input int k,
                        input logic hold_mid);
        int         w;
        int         ack_at;
        logic       to;
        logic       strobe;
        logic [7:0] old_rd;
        logic [7:0] new_rd;
        w      = (k < MAXW) ? k : MAXW;
        to     = (k > MAXW);
        ack_at = 4 + w;
        old_rd = exp_rdata;
        new_rd = to ? 8'hFF : (we ? exp_rdata : din);
        bif.req       = 1'b1;
        bif.req_we    = we;
        bif.req_iom   = iom;
        bif.req_addr  = addr;
        bif.req_wdata = wd;
        for (int i = 1; i <= ack_at; i++) begin
            @(negedge CLK);
            strobe = (i >= 2) && (i <= 3 + w);
            chk("ale",     bif.ALE,     i == 1);
            chk("rd_n",    bif.RD,      !(strobe && !we));
            chk("wr_n",    bif.WR,      !(strobe && we));
            chk("den_n",   bif.DEN,     !strobe);
            chk("data_oe", bif.Data_oe, strobe && we);
            if (strobe && we) chk("data_out", bif.Data_out, wd);
            chk("address", bif.Address, addr);
            chk("iom",     bif.IOM,     iom);
            chk("dtr",     bif.DTR,     we);
            chk("ack",     bif.ack,     i == ack_at);
            chk("err",     bif.err,     (i == ack_at) && to);
            chk("rdata",   bif.rdata,   (i == ack_at) ? new_rd : old_rd);
            chk("busy",    bif.busy,    1);
            chk("hlda",    bif.HLDA,    0);
            chk("bus_oe",  bif.bus_oe,  1);
            bif.READY   = !((i >= 3) && (i < 3 + k));
            bif.Data_in = (i == 3 + k) ? din : ~din;
            if (hold_mid && i == 2) bif.HOLD = 1'b1;
            if (i == ack_at) bif.req = 1'b0;
        end
        exp_rdata = new_rd;
        @(negedge CLK);
        chk("post_busy", bif.busy, 0);
        chk("post_ack",  bif.ack,  0);
        chk("post_err",  bif.err,  0);
        chk("post_ale",  bif.ALE,  0);
        chk("post_rd_n", bif.RD,   1);
        chk("post_wr_n", bif.WR,   1);
        chk("post_hlda", bif.HLDA, 0);
        chk("post_rdata", bif.rdata, exp_rdata);
    endtask

    task automatic do_hold(input int len, input logic with_req);
        bif.HOLD   = 1'b1;
        bif.req    = with_req;
        bif.req_we = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            chk("th_hlda",    bif.HLDA,    1);
            chk("th_bus_oe",  bif.bus_oe,  0);
            chk("th_ale",     bif.ALE,     0);
            chk("th_busy",    bif.busy,    0);
            chk("th_rd_n",    bif.RD,      1);
            chk("th_wr_n",    bif.WR,      1);
            chk("th_den_n",   bif.DEN,     1);
            chk("th_data_oe", bif.Data_oe, 0);
            chk("th_ack",     bif.ack,     0);
        end
        bif.HOLD = 1'b0;
        @(negedge CLK);
        chk("ti_hlda",   bif.HLDA,   0);
        chk("ti_bus_oe", bif.bus_oe, 1);
        chk("ti_ale",    bif.ALE,    0);
        chk("ti_busy",   bif.busy,   0);
    endtask

    task automatic idle(input int n);
        bif.req  = 1'b0;
        bif.HOLD = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("idle_busy", bif.busy, 0);
            chk("idle_ack",  bif.ack,  0);
            chk("idle_ale",  bif.ALE,  0);
            chk("idle_hlda", bif.HLDA, 0);
        end
    endtask

    initial begin
        logic       r_we;
        logic       r_iom;
        logic       r_hm;
        logic [19:0] r_addr;
        logic [7:0] r_wd;
        logic [7:0] r_din;
        int         r_sel;
        int         r_k;

        RESET         = 1'b1;
        bif.req       = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_iom   = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.READY     = 1'b1;
        bif.Data_in   = 8'h00;
        bif.HOLD      = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ale",      bif.ALE,      0);
        chk("rst_rd_n",     bif.RD,       1);
        chk("rst_wr_n",     bif.WR,       1);
        chk("rst_den_n",    bif.DEN,      1);
        chk("rst_dtr",      bif.DTR,      1);
        chk("rst_iom",      bif.IOM,      0);
        chk("rst_address",  bif.Address,  0);
        chk("rst_data_out", bif.Data_out, 0);
        chk("rst_data_oe",  bif.Data_oe,  0);
        chk("rst_ack",      bif.ack,      0);
        chk("rst_err",      bif.err,      0);
        chk("rst_rdata",    bif.rdata,    0);
        chk("rst_busy",     bif.busy,     0);
        chk("rst_hlda",     bif.HLDA,     0);
        chk("rst_bus_oe",   bif.bus_oe,   1);
        RESET = 1'b0;
        idle(2);

        xfer(1'b0, 1'b0, 20'h00100, 8'h00, 8'hA5, 0, 1'b0);
        xfer(1'b1, 1'b0, 20'hFFFFF, 8'h3C, 8'h00, 0, 1'b0);
        xfer(1'b0, 1'b1, 20'h00321, 8'h00, 8'h7E, 3, 1'b0);
        xfer(1'b0, 1'b0, 20'h2468A, 8'h00, 8'h11, 20, 1'b0);
        xfer(1'b0, 1'b0, 20'h13579, 8'h00, 8'h42, MAXW, 1'b0);
        xfer(1'b0, 1'b1, 20'h0F00F, 8'h00, 8'hC3, MAXW - 1, 1'b0);
        xfer(1'b1, 1'b1, 20'h00080, 8'hE7, 8'h00, 2, 1'b0);

        do_hold(3, 1'b1);
        xfer(1'b0, 1'b0, 20'h0ABCD, 8'h00, 8'h99, 0, 1'b0);

        xfer(1'b1, 1'b0, 20'h55555, 8'h12, 8'h00, 1, 1'b1);
        do_hold(2, 1'b0);

        // Reset lands while a write sits in T3.
        bif.req       = 1'b1;
        bif.req_we    = 1'b1;
        bif.req_iom   = 1'b0;
        bif.req_addr  = 20'h12345;
        bif.req_wdata = 8'h5A;
        bif.READY     = 1'b1;
        repeat (3) @(negedge CLK);
        chk("t3_wr_n", bif.WR, 0);
        RESET   = 1'b1;
        bif.req = 1'b0;
        @(negedge CLK);
        exp_rdata = 8'h00;
        chk("mid_rst_wr_n",    bif.WR,      1);
        chk("mid_rst_den_n",   bif.DEN,     1);
        chk("mid_rst_data_oe", bif.Data_oe, 0);
        chk("mid_rst_ack",     bif.ack,     0);
        chk("mid_rst_busy",    bif.busy,    0);
        chk("mid_rst_address", bif.Address, 0);
        RESET = 1'b0;
        idle(2);
        xfer(1'b0, 1'b0, 20'h00200, 8'h00, 8'h6D, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_iom  = 1'($urandom_range(0, 1));
            r_addr = 20'($urandom);
            r_wd   = 8'($urandom);
            r_din  = 8'($urandom);
            r_sel  = int'($urandom_range(0, 9));
            if (r_sel < 6)      r_k = int'($urandom_range(0, 3));
            else if (r_sel < 8) r_k = 0;
            else                r_k = int'($urandom_range(MAXW - 2, MAXW + 2));
            r_hm = ($urandom_range(0, 7) == 0);
            xfer(r_we, r_iom, r_addr, r_wd, r_din, r_k, r_hm);
            if (r_hm) do_hold(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Minimum-mode 8088-style bus cycle generator that sits directly upstream of the memory model and drives its ALE, RD, WR, IOM, Address and data lines. It accepts single-byte read/write requests from the execution side over a req/ack handshake and sequences each one through T1–T4 bus states. It inserts wait states on READY, with a timeout, and supports HOLD/HLDA bus release.

## Interface
Parameters:
- MAX_WAIT, 15: maximum consecutive TW cycles before timeout (1..255).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high.
- req  in  1  request a bus cycle; held until ack.
- req_we  in  1  1 = write, 0 = read.
- req_iom  in  1  1 = I/O, 0 = memory.
- req_addr  in  20  byte address.
- req_wdata  in  8  write data.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = wait timeout.
- rdata  out  8  read data, valid with ack on reads.
- busy  out  1  cycle in progress, from the accept edge until the ack cycle inclusive.
- READY  in  1  1 = slave ready, sampled in T3/TW.
- Data_in  in  8  bus read data.
- Data_out  out  8  bus write data.
- Data_oe  out  1  Data_out drive enable.
- Address  out  20  latched bus address.
- ALE  out  1  address latch enable, active-high.
- IOM  out  1  1 = I/O cycle.
- RD  out  1  read strobe, active-low.
- WR  out  1  write strobe, active-low.
- DTR  out  1  1 = transmit (write), 0 = receive.
- DEN  out  1  data enable, active-low.
- HOLD  in  1  bus request from an external master.
- HLDA  out  1  hold acknowledge.
- bus_oe  out  1  0 = bus outputs released (TH).

## Operation
- States: TI, T1, T2, T3, TW, T4, TH.
- Transitions:
  - TI→TH if HOLD. HOLD has priority over a simultaneous req.
  - TI→T1 if req. Accepts and latches req_we, req_iom, req_addr and req_wdata.
  - T1→T2, T2→T3.
  - T3/TW→T4 if READY.
  - T3/TW→TW if !READY and the wait count is below MAX_WAIT.
  - TW→T4 with a timeout when the count reaches MAX_WAIT.
  - T4→TI always.
  - TH→TI when HOLD=0.
- HOLD asserted mid-cycle is ignored until the cycle reaches TI.
- Outputs are registered and decoded from the next state, so they take their new value on the edge entering that state.
- T1:
  - ALE=1.
  - Address and IOM take the latched values.
  - DTR=req_we.
- T2, T3, TW:
  - ALE=0 and DEN=0.
  - Read: RD=0.
  - Write: WR=0, Data_oe=1, Data_out=wdata.
- T4:
  - RD=1, WR=1, DEN=1, Data_oe=0.
  - ack=1.
  - Address, IOM and DTR hold their values.
- Read data:
  - On the edge leaving T3/TW with READY=1, rdata←Data_in.
  - On timeout, rdata←8'hFF and err=1 with ack.
  - rdata holds its value until the next read completes.
- Wait counter:
  - Cleared in T2.
  - Increments on each cycle spent in TW.
  - Saturates at MAX_WAIT.
- TH:
  - HLDA=1, bus_oe=0.
  - ALE=0, RD=1, WR=1, DEN=1, Data_oe=0.

## Timing
- Reset values:
  - State TI.
  - ALE=0, RD=1, WR=1, DEN=1, DTR=1, IOM=0.
  - Address=0, Data_out=0, Data_oe=0.
  - ack=0, err=0, rdata=0, busy=0.
  - HLDA=0, bus_oe=1.
- Zero-wait cycle: req seen in TI at edge n gives T1 at n+1, T2 at n+2, T3 at n+3 and T4/ack at n+4; TI at n+5.
  - Minimum issue interval is 5 cycles.
  - Each TW adds 1 cycle.
- ALE is high for exactly one cycle per bus cycle.
- RD/WR are low for 2+W cycles, where W is the number of wait states.
- req must stay high until ack. A req still high in the cycle after ack is a new request.
- err is 0 whenever ack is 0.
- Reset mid-cycle: TI on the next edge, no ack, strobes deasserted.

## Structure
- Package biu_pkg:
  - bus_state_t: one-hot 7-bit enum {TI, T1, T2, T3, TW, T4, TH}.
  - bus_req_t: struct {we, iom, addr[19:0], wdata[7:0]}.
  - Constants DATA_W=8 and ADDR_W=20.
- Sub-module wait_timer:
  - Inputs: clear, count enable.
  - Output: expired when the count reaches MAX_WAIT.

## Test plan
- Memory read, addr 20'h00100, READY=1, Data_in=8'hA5:
  - ALE at n+1, RD low at n+2..n+3.
  - ack with rdata=8'hA5 and err=0 at n+4.
- Memory write, addr 20'hFFFFF, wdata=8'h3C:
  - DTR=1, WR low and Data_oe=1 with Data_out=8'h3C for two cycles.
  - ack at n+4, IOM=0.
- I/O read with READY low for 3 cycles:
  - IOM=1, three TW states, ack at n+7, RD low for 5 cycles.
- READY held low, MAX_WAIT=15:
  - ack at n+19 with err=1 and rdata=8'hFF.
- HOLD and req asserted together in TI:
  - TH entered with HLDA=1 and bus_oe=0, no ALE.
  - HOLD drops: TI, then the read proceeds from T1.
- RESET asserted in T3 of a write:
  - Next edge: WR=1, DEN=1, Data_oe=0, no ack, state TI.
